// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: one word per valid/ready handshake, first bit one cycle later,
// each bit held DIV clocks. A new word is accepted only in IDLE or during the last clock of the last bit.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int DIV        = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [WIDTH-1:0] i_data_in,
  output logic             o_data_out,
  output logic             o_bit_strobe,
  output logic             o_busy,
  output logic             o_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic [DW-1:0]    r_div_cnt;
  logic             r_data_out;
  logic             r_bit_strobe;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [BW-1:0]    w_bit_cnt_nxt;
  logic [DW-1:0]    w_div_cnt_nxt;
  logic             w_data_out_nxt;
  logic             w_bit_strobe_nxt;
  logic             w_done_nxt;

  logic             w_div_end;
  logic             w_last;
  logic             w_handshake;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;

  // The bit on the line is always the head of the shift register, so after a
  // shift the next output bit is the one just behind the current head.
  assign w_first_bit = MSB_FIRST ? i_data_in[WIDTH-1] : i_data_in[0];
  assign w_shifted   = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
  assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];

  assign w_div_end   = (r_div_cnt == DIV_LAST);
  assign w_last      = (r_state == S_SHIFT) && (r_bit_cnt == BIT_LAST) && w_div_end;
  assign w_handshake = i_load_valid && o_load_ready;

  assign o_load_ready = (r_state == S_IDLE) || w_last;
  assign o_busy       = (r_state == S_SHIFT);
  assign o_data_out   = r_data_out;
  assign o_bit_strobe = r_bit_strobe;
  assign o_done       = r_done;

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_div_cnt_nxt    = r_div_cnt;
    w_data_out_nxt   = r_data_out;
    w_bit_strobe_nxt = 1'b0;
    w_done_nxt       = 1'b0;

    if (w_handshake) begin
      // A load on the last bit period still finishes the old word, hence Done.
      w_state_nxt      = S_SHIFT;
      w_shift_nxt      = i_data_in;
      w_bit_cnt_nxt    = '0;
      w_div_cnt_nxt    = '0;
      w_data_out_nxt   = w_first_bit;
      w_bit_strobe_nxt = 1'b1;
      w_done_nxt       = w_last;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (w_div_end) begin
            w_div_cnt_nxt = '0;
            if (r_bit_cnt == BIT_LAST) begin
              w_state_nxt    = S_IDLE;
              w_shift_nxt    = '0;
              w_bit_cnt_nxt  = '0;
              w_data_out_nxt = IDLE_LEVEL;
              w_done_nxt     = 1'b1;
            end else begin
              w_shift_nxt      = w_shifted;
              w_bit_cnt_nxt    = r_bit_cnt + BW'(1);
              w_data_out_nxt   = w_next_bit;
              w_bit_strobe_nxt = 1'b1;
            end
          end else begin
            w_div_cnt_nxt = r_div_cnt + DW'(1);
          end
        end
        default: begin
          w_data_out_nxt = IDLE_LEVEL;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_data_out   <= IDLE_LEVEL;
      r_bit_strobe <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_div_cnt    <= w_div_cnt_nxt;
      r_data_out   <= w_data_out_nxt;
      r_bit_strobe <= w_bit_strobe_nxt;
      r_done       <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Three serializer instances (default, LSB-first, DIV=4) exercised one at a time;
// expected bit sequences are queued at load time and checked by a negedge monitor.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [2:0] lv;
  logic [7:0] din [3];
  wire  [2:0] lr;
  wire  [2:0] dout;
  wire  [2:0] strb;
  wire  [2:0] busy;
  wire  [2:0] done;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  bit exp_q[$];
  bit cur [3];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .DIV(1), .IDLE_LEVEL(1'b0)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_load_valid(lv[0]), .o_load_ready(lr[0]),
    .i_data_in(din[0]), .o_data_out(dout[0]), .o_bit_strobe(strb[0]),
    .o_busy(busy[0]), .o_done(done[0])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .DIV(1), .IDLE_LEVEL(1'b0)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_load_valid(lv[1]), .o_load_ready(lr[1]),
    .i_data_in(din[1]), .o_data_out(dout[1]), .o_bit_strobe(strb[1]),
    .o_busy(busy[1]), .o_done(done[1])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .DIV(4), .IDLE_LEVEL(1'b0)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_load_valid(lv[2]), .o_load_ready(lr[2]),
    .i_data_in(din[2]), .o_data_out(dout[2]), .o_bit_strobe(strb[2]),
    .o_busy(busy[2]), .o_done(done[2])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe pops the next expected bit; the line must then hold it
  // for as long as Busy is high, and sit at the idle level otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int k = 0; k < 3; k++) begin
          if (strb[k] === 1'b1) begin
            if (exp_q.size() == 0) chk($sformatf("strobe_without_expected[%0d]", k), 32'(strb[k]), 0);
            else cur[k] = exp_q.pop_front();
          end
          if (busy[k] === 1'b1) chk($sformatf("data_out[%0d]", k), 32'(dout[k]), 32'(cur[k]));
          else chk($sformatf("idle_level[%0d]", k), 32'(dout[k]), 0);
        end
      end
    end
  end

  // seq holds the hand-computed output order, first bit in seq[7].
  task automatic do_word(input int k, input logic [7:0] d, input logic [7:0] seq,
                         input int div, input string tag);
    lv[k]  = 1'b1;
    din[k] = d;
    for (int i = 7; i >= 0; i--) exp_q.push_back(seq[i]);
    chk({tag, "_ready_idle"}, 32'(lr[k]), 1);
    step();
    lv[k] = 1'b0;
    for (int c = 1; c <= 8 * div; c++) begin
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy[k]), 1);
      chk($sformatf("%s_done_c%0d", tag, c), 32'(done[k]), 0);
      chk($sformatf("%s_strobe_c%0d", tag, c), 32'(strb[k]), ((c - 1) % div == 0) ? 1 : 0);
      if (c < 8 * div) step();
    end
    step();
    chk({tag, "_end_busy"}, 32'(busy[k]), 0);
    chk({tag, "_end_done"}, 32'(done[k]), 1);
    step();
    chk({tag, "_done_one_cycle"}, 32'(done[k]), 0);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    lv  = '0;
    for (int k = 0; k < 3; k++) din[k] = '0;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_dout[%0d]", k), 32'(dout[k]), 0);
      chk($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 0);
      chk($sformatf("rst_done[%0d]", k), 32'(done[k]), 0);
      chk($sformatf("rst_strobe[%0d]", k), 32'(strb[k]), 0);
      chk($sformatf("rst_ready[%0d]", k), 32'(lr[k]), 1);
    end
    mon_en = 1'b1;
    rst    = 1'b0;
    step();

    do_word(0, 8'hA5, 8'b10100101, 1, "msb_a5");
    do_word(1, 8'h0F, 8'b11110000, 1, "lsb_0f");
    do_word(0, 8'h0F, 8'b00001111, 1, "msb_0f");
    do_word(1, 8'h3A, 8'b01011100, 1, "lsb_3a");
    do_word(2, 8'h80, 8'b10000000, 4, "div4_80");
    do_word(2, 8'hC9, 8'b11001001, 4, "div4_c9");

    // Back-to-back words with Load_Valid held high.
    lv[0]  = 1'b1;
    din[0] = 8'hFF;
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    step();
    din[0] = 8'h00;
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
    for (int c = 1; c <= 16; c++) begin
      if (c == 9) lv[0] = 1'b0;
      chk($sformatf("b2b_busy_c%0d", c), 32'(busy[0]), 1);
      chk($sformatf("b2b_strobe_c%0d", c), 32'(strb[0]), 1);
      chk($sformatf("b2b_done_c%0d", c), 32'(done[0]), (c == 9) ? 1 : 0);
      chk($sformatf("b2b_ready_c%0d", c), 32'(lr[0]), (c == 8 || c == 16) ? 1 : 0);
      if (c < 16) step();
    end
    step();
    chk("b2b_end_busy", 32'(busy[0]), 0);
    chk("b2b_end_done", 32'(done[0]), 1);
    step();
    chk("b2b_done_one_cycle", 32'(done[0]), 0);
    chk("b2b_queue_drained", exp_q.size(), 0);

    // A load request mid-word must be refused and leave the word intact.
    lv[0]  = 1'b1;
    din[0] = 8'hF0;
    for (int i = 0; i < 8; i++) exp_q.push_back(i < 4);
    step();
    lv[0] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 4) begin
        lv[0]  = 1'b1;
        din[0] = 8'h0F;
        chk("busy_load_ready", 32'(lr[0]), 0);
      end
      if (c == 5) lv[0] = 1'b0;
      chk($sformatf("ign_busy_c%0d", c), 32'(busy[0]), 1);
      if (c < 8) step();
    end
    step();
    chk("ign_end_done", 32'(done[0]), 1);
    chk("ign_end_busy", 32'(busy[0]), 0);
    step();
    chk("ign_stays_idle", 32'(busy[0]), 0);
    chk("ign_queue_drained", exp_q.size(), 0);

    // Reset during bit 3 aborts the word without a Done pulse.
    lv[0]  = 1'b1;
    din[0] = 8'hFF;
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
    step();
    lv[0] = 1'b0;
    step();
    step();
    step();
    chk("abort_busy_before", 32'(busy[0]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_dout", 32'(dout[0]), 0);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_done", 32'(done[0]), 0);
    chk("abort_strobe", 32'(strb[0]), 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("abort_no_done_c%0d", c), 32'(done[0]), 0);
      chk($sformatf("abort_idle_c%0d", c), 32'(busy[0]), 0);
    end
    chk("abort_queue_drained", exp_q.size(), 0);

    // Reset wins over a same-cycle load.
    rst    = 1'b1;
    lv[0]  = 1'b1;
    din[0] = 8'hAA;
    step();
    rst   = 1'b0;
    lv[0] = 1'b0;
    chk("rst_load_busy", 32'(busy[0]), 0);
    chk("rst_load_strobe", 32'(strb[0]), 0);
    step();
    chk("rst_load_busy_later", 32'(busy[0]), 0);
    chk("rst_load_dout_later", 32'(dout[0]), 0);
    step();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
